// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and the MEM stage.
// Define MISALIGN_TRAP_EN to trap misaligned half/word data accesses instead of issuing them.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_fault,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);

    state_t            state_q;
    logic [3:0]        streak_q;
    logic [2:0]        latCnt_q;
    logic              grantData_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [1:0]        addrLo_q;
    logic [31:0]       ifRdata_q;
    logic              ifValid_q;
    logic [31:0]       dRdata_q;
    logic              dValid_q;
    logic              memEn_q;
    logic              memWe_q;
    logic [3:0]        memBe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [31:0]       memWdata_q;

    logic              grant;
    logic              dataWins;
    logic              trapD;
    logic [3:0]        streakD;
    logic [3:0]        beD;
    logic [31:0]       wdataD;
    logic [ADDR_W-1:0] addrD;
    logic [31:0]       laneShifted;
    logic [15:0]       halfSel;
    logic [31:0]       loadD;
    logic              unusedIfLow;

    assign unusedIfLow = ^if_addr[1:0];

    // Data wins a tie unless it has already taken MAX_D_STREAK grants in a row over a waiting fetch.
    assign grant    = d_req | if_req;
    assign dataWins = d_req & ~(if_req & (streak_q == STREAK_MAX));
    assign addrD    = dataWins ? {d_addr[ADDR_W-1:2], 2'b00} : {if_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        streakD = streak_q;
        if (dataWins) begin
            if (if_req && streak_q != STREAK_MAX) begin
                streakD = streak_q + 4'd1;
            end
        end else if (if_req) begin
            streakD = '0;
        end
    end

    always_comb begin
        beD    = 4'b1111;
        wdataD = d_wdata;
        if (dataWins && d_we) begin
            case (d_size)
                2'b00: begin
                    beD    = 4'b0001 << d_addr[1:0];
                    wdataD = {4{d_wdata[7:0]}};
                end
                2'b01: begin
                    beD    = d_addr[1] ? 4'b1100 : 4'b0011;
                    wdataD = {2{d_wdata[15:0]}};
                end
                default: begin
                    beD    = 4'b1111;
                    wdataD = d_wdata;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalignD;
    logic dFault_q;

    always_comb begin
        misalignD = 1'b0;
        if (d_size == 2'b01) begin
            misalignD = d_addr[0];
        end else if (d_size[1]) begin
            misalignD = (d_addr[1:0] != 2'b00);
        end
    end

    assign trapD   = dataWins & misalignD;
    assign d_fault = dFault_q;
`else
    assign trapD   = 1'b0;
    assign d_fault = 1'b0;
`endif

    // Loads pick their lane out of the returned word and extend it.
    always_comb begin
        laneShifted = mem_rdata >> {addrLo_q, 3'b000};
        halfSel     = addrLo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   loadD = {{24{~unsigned_q & laneShifted[7]}}, laneShifted[7:0]};
            2'b01:   loadD = {{16{~unsigned_q & halfSel[15]}}, halfSel};
            default: loadD = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            latCnt_q    <= '0;
            grantData_q <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            addrLo_q    <= '0;
            ifRdata_q   <= '0;
            ifValid_q   <= 1'b0;
            dRdata_q    <= '0;
            dValid_q    <= 1'b0;
            memEn_q     <= 1'b0;
            memWe_q     <= 1'b0;
            memBe_q     <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            dFault_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        grantData_q <= dataWins;
                        we_q        <= dataWins & d_we;
                        size_q      <= d_size;
                        unsigned_q  <= d_unsigned;
                        addrLo_q    <= dataWins ? d_addr[1:0] : 2'b00;
                        streak_q    <= streakD;
                        if (trapD) begin
                            state_q  <= DONE;
                            dValid_q <= 1'b1;
                            dRdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
                            dFault_q <= 1'b1;
`endif
                        end else begin
                            state_q    <= ISSUE;
                            memEn_q    <= 1'b1;
                            memWe_q    <= dataWins & d_we;
                            memBe_q    <= beD;
                            memAddr_q  <= addrD;
                            memWdata_q <= wdataD;
                        end
                    end
                end
                ISSUE: begin
                    memEn_q <= 1'b0;
                    memWe_q <= 1'b0;
                    if (we_q) begin
                        state_q  <= DONE;
                        dValid_q <= 1'b1;
                    end else begin
                        state_q  <= WAIT;
                        latCnt_q <= LAT_INIT;
                    end
                end
                WAIT: begin
                    if (latCnt_q == 3'd0) begin
                        state_q <= DONE;
                        if (grantData_q) begin
                            dRdata_q <= loadD;
                            dValid_q <= 1'b1;
                        end else begin
                            ifRdata_q <= mem_rdata;
                            ifValid_q <= 1'b1;
                        end
                    end else begin
                        latCnt_q <= latCnt_q - 3'd1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    ifValid_q <= 1'b0;
                    dValid_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    dFault_q  <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = ifRdata_q;
    assign if_valid  = ifValid_q;
    assign d_rdata   = dRdata_q;
    assign d_valid   = dValid_q;
    assign mem_en    = memEn_q;
    assign mem_we    = memWe_q;
    assign mem_be    = memBe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Grants one requester per transaction and drives the memory port, including byte enables and store-data lane replication.
- Returns sign/zero-extended load data.
- Pipeline stall logic holds a requester while it waits for its valid pulse.

Parameters:
ADDR_W, 32, byte-address width of both requesters and memory port
MEM_LAT, 1, cycles from mem_en to mem_rdata valid (legal range 1..7)
MAX_D_STREAK, 2, max consecutive data grants while a fetch is pending (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch byte address (word aligned)
if_rdata  out  32  fetched instruction, meaningful when if_valid=1
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_valid
d_we  in  1  1=store, 0=load
d_size  in  2  00=byte, 01=half, 10/11=word
d_unsigned  in  1  1=zero-extend the load (LBU/LHU)
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-aligned
d_rdata  out  32  extended load data, meaningful when d_valid=1
d_valid  out  1  one-cycle data completion pulse
d_fault  out  1  misaligned-access flag, qualified by d_valid (see Optional Feature)
mem_en  out  1  memory access strobe, exactly one cycle per transaction
mem_we  out  1  write enable, qualified by mem_en
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read word

Behaviour:
- Clock/reset: all flops reset asynchronously on rst_n=0.
  - Reset values: all outputs 0, state IDLE, streak counter 0, latency counter 0.
  - A reset mid-transaction discards the in-flight access; no valid pulse follows.
- States: IDLE, ISSUE, WAIT, DONE.
- Requests are sampled only in IDLE. Inputs must stay stable from req assertion through the valid cycle.
- IDLE arbitration:
  - d_req only -> data.
  - if_req only -> fetch.
  - Both -> data, unless streak==MAX_D_STREAK, then fetch.
  - Neither -> stay in IDLE.
- Streak counter: increments on a data grant while if_req=1; clears on any fetch grant; saturates at MAX_D_STREAK.
- IDLE -> ISSUE on a grant. The winner's address/size/wdata are registered.
- ISSUE: mem_en=1 for this single cycle with registered mem_we/mem_be/mem_addr/mem_wdata.
  - Store -> DONE.
  - Load/fetch -> WAIT, latency counter loaded with MEM_LAT-1.
- WAIT: counter decrements. At 0, mem_rdata is captured (MEM_LAT cycles after the ISSUE cycle) and the state goes to DONE.
- DONE: the granted requester's valid=1 with registered rdata; next state IDLE.
  - Load latency, req-sample to valid: MEM_LAT+2 cycles.
  - Store latency, req-sample to valid: 2 cycles.
  - Minimum spacing between grants: 3 cycles (stores), MEM_LAT+3 (loads).
- Byte enables, with a = addr[1:0]:
  - byte: be=1<<a, wdata={4{wdata[7:0]}}.
  - half: be=a[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - word: be=1111.
  - Loads drive be=1111.
  - Fetch: be=1111, we=0.
- Load extraction:
  - byte = word[8a+7:8a]; half = a[1] ? word[31:16] : word[15:0].
  - Sign-extend from the top bit unless d_unsigned=1. d_unsigned is ignored for word loads.
- Fetch data passes through unmodified.
- Any valid output is 0 outside DONE. rdata holds its last value.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A data request is misaligned if it is a half with a[0]=1 or a word with a!=0.
  - On grant, a misaligned request skips ISSUE/WAIT, goes IDLE->DONE, and never asserts mem_en.
  - d_valid=1, d_fault=1, d_rdata=0.
  - The streak counter still updates.
- Undefined:
  - d_fault is constant 0.
  - Word accesses ignore a.
  - Half accesses ignore a[0].
  - No trap path exists.

Test Plan:
- Reset: rst_n low mid-WAIT -> all outputs 0 immediately; after release, no if_valid/d_valid pulse for the aborted request.
- LB sign extension: MEM_LAT=1, mem word 0x80FF7F01 at 0x100, LB addr 0x103 -> d_valid 3 cycles after sample, d_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH upper half: d_addr=0x202, d_wdata=0x0000BEEF -> in the ISSUE cycle mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x200, mem_we=1; d_valid 2 cycles after sample.
- Streak fairness: MAX_D_STREAK=2, if_req and d_req held high continuously -> grant order D,D,I,D,D,I; if_rdata equals the memory word at if_addr.
- Single requester: if_req only, MEM_LAT=3 -> mem_en exactly once; if_valid 5 cycles after the sample cycle.
- With MISALIGN_TRAP_EN: LW addr 0x102 -> mem_en never asserts; d_valid=1, d_fault=1, d_rdata=0 one cycle after grant. Without the macro, the same request reads word 0x100.
